key_debounce_pulse: RTL and testbench
=====================================

Name: key_debounce_pulse

Overview:
- Front-end conditioner for the board push-buttons (KEY[3:0], active-low).
- Drives the digit-entry/display stage, which latches a switch value per button event and must see one clean event per physical press.
- Per key: synchronizes, debounces, and emits single-cycle press/release pulses plus a stable level.
- Sits between the KEY pins and the seven-segment entry logic, all in the CLOCK_125_p domain.

Parameters:
- NUM_KEYS, 4, number of independent key channels.
- DEBOUNCE_CYCLES, 1250000, consecutive stable samples needed to accept a change (10 ms at 125 MHz). Minimum 2.
- REPEAT_DELAY, 62500000, cycles held before the first auto-repeat pulse (0.5 s). Used only with AUTOREPEAT_EN.
- REPEAT_PERIOD, 12500000, cycles between subsequent auto-repeat pulses (0.1 s). Used only with AUTOREPEAT_EN.

Ports:
- CLOCK_125_p  input  1  system clock, 125 MHz.
- rst  input  1  asynchronous active-high reset.
- key_n  input  NUM_KEYS  raw button pins, asynchronous, 0 = pressed.
- key_level  output  NUM_KEYS  debounced state, 1 = pressed.
- key_press  output  NUM_KEYS  one-cycle pulse on each accepted press (and on repeats when enabled).
- key_release  output  NUM_KEYS  one-cycle pulse on each accepted release.

Behaviour:
- Reset is async assert, sync release (deassert sampled on CLOCK_125_p). Reset values:
  - synchronizer flops: 1 (released);
  - key_level, key_press, key_release: 0;
  - counters: 0;
  - FSM: RELEASED.
- Synchronizer: 2 flops per key. s = ~sync2 gives 1 = pressed.
- Per-key FSM with states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT:
  - RELEASED: s=1 -> PRESS_WAIT, cnt cleared.
  - PRESS_WAIT:
    - s=0 -> RELEASED, cnt cleared (bounce rejected);
    - s=1 -> cnt++;
    - when cnt reaches DEBOUNCE_CYCLES-1 with s=1 -> PRESSED, registered key_press=1 next cycle, key_level=1 next cycle.
  - PRESSED: s=0 -> RELEASE_WAIT, cnt cleared.
  - RELEASE_WAIT: mirror of PRESS_WAIT.
    - s=1 -> PRESSED (bounce rejected);
    - DEBOUNCE_CYCLES consecutive s=0 samples -> RELEASED, key_release=1 for one cycle, key_level=0.
- Latency:
  - A clean edge on key_n sampled at edge E0 gives key_press/key_release high during the cycle after edge E0+2+DEBOUNCE_CYCLES.
  - It is exactly one cycle wide.
- Counter: width $clog2(DEBOUNCE_CYCLES+1). Saturates and never wraps. Cleared on every state change.
- Pulses:
  - key_press and key_release for one key are never high in the same cycle.
  - Minimum spacing between a press pulse and a release pulse is DEBOUNCE_CYCLES+1 cycles.
- Keys are fully independent. Simultaneous presses on several keys give pulses in the same cycle.
- Reset mid-debounce or mid-press: all state returns to RELEASED immediately. No pulse is emitted on reset assertion or deassertion.
  - A key held across reset release is accepted as a new press after the full latency.
- Glitch shorter than 1 cycle: it may or may not be captured by the synchronizer, but it can never produce a pulse unless it persists for DEBOUNCE_CYCLES cycles.

Optional Feature:
- Macro: KEY_DEBOUNCE_AUTOREPEAT_EN.
- Defined:
  - In PRESSED, a repeat counter starts at 0 on entry.
  - When it reaches REPEAT_DELAY, key_press pulses once and the counter reloads for REPEAT_PERIOD.
  - Pulses then recur every REPEAT_PERIOD cycles while held.
  - Leaving PRESSED (including entering RELEASE_WAIT) clears the repeat counter.
  - Returning from RELEASE_WAIT to PRESSED restarts REPEAT_DELAY.
- Undefined:
  - Exactly one key_press per accepted press.
  - No repeat counter or logic synthesized. REPEAT_* parameters are ignored.

Decomposition:
- Package key_pkg holds:
  - the key_state_t enum (RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT);
  - localparam SYNC_STAGES = 2;
  - a function returning counter width.
- Sub-module key_debounce_cell: one synchronizer, FSM, and counter (plus the repeat counter when enabled), 1-bit ports.
- Top instantiates NUM_KEYS cells in a generate loop.

Test Plan:
- Test parameters: DEBOUNCE_CYCLES=8, REPEAT_DELAY=40, REPEAT_PERIOD=10, NUM_KEYS=4.
- Clean press: key_n[1] 1->0 held 20 cycles -> key_press[1] one cycle high at +11 cycles, key_level[1]=1 from then; others stay 0.
- Bounce: key_n[0] toggles low/high with 3-cycle halves for 30 cycles, then held low -> no pulse during bounce; one key_press[0] 11 cycles after the final stable low.
- Release: after an accepted press, key_n[0] 0->1 -> key_release[0] pulse at +11, key_level[0]=0; a 5-cycle low glitch while pressed yields no release.
- Reset mid-operation: rst asserted at PRESS_WAIT cnt=5 -> outputs 0 immediately; key held through reset release -> press pulse 11 cycles after release, no pulse at reset edges.
- Simultaneous: key_n=4'b0000 at once -> key_press=4'b1111 in the same single cycle.
- Auto-repeat (macro defined): key held 100 cycles after acceptance -> extra key_press pulses at +40, +50, +60 … after acceptance. Macro undefined -> exactly one pulse.

Source files
------------

// File: rtl/key_pkg.sv
// Shared definitions for the push-button conditioner.
//   key_state_t  : per-key debounce FSM states
//   SYNC_STAGES  : depth of the input synchronizer
//   cnt_width()  : width of a counter that must hold values 0..max_val
package key_pkg;

  typedef enum logic [1:0] {
    Released,
    PressWait,
    Pressed,
    ReleaseWait
  } key_state_t;

  localparam int unsigned SYNC_STAGES = 2;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One key channel: 2-flop synchronizer, debounce FSM with stable-sample counter, and
// registered single-cycle press/release pulses plus a debounced level.
// Optional auto-repeat on a held key when KEY_DEBOUNCE_AUTOREPEAT_EN is defined.
//   clk_i      : clock
//   rst_i      : asynchronous active-high reset
//   key_n_i    : raw key pin, 0 = pressed
//   level_o    : debounced state, 1 = pressed
//   press_o    : one-cycle pulse per accepted press (and per repeat when enabled)
//   release_o  : one-cycle pulse per accepted release
module key_debounce_cell
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1250000,
  parameter int unsigned REPEAT_DELAY    = 62500000,
  parameter int unsigned REPEAT_PERIOD   = 12500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end

  localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  key_state_t             state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;

  assign s = ~sync_q[SYNC_STAGES-1];

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
  localparam int unsigned RepMax =
      (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RepW = cnt_width(RepMax);
  localparam logic [RepW-1:0] RepDelayLast  = RepW'(REPEAT_DELAY - 1);
  localparam logic [RepW-1:0] RepPeriodLast = RepW'(REPEAT_PERIOD - 1);

  logic [RepW-1:0] rep_q, rep_d;
  // Set after the first repeat so later ones use the shorter period.
  logic            rep_armed_q, rep_armed_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rep_q       <= '0;
      rep_armed_q <= 1'b0;
    end else begin
      rep_q       <= rep_d;
      rep_armed_q <= rep_armed_d;
    end
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q    <= '1;
      state_q   <= Released;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], key_n_i};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    rep_d       = '0;
    rep_armed_d = 1'b0;
`endif
    unique case (state_q)
      Released: begin
        cnt_d = '0;
        if (s) state_d = PressWait;
      end
      PressWait: begin
        if (!s) begin
          state_d = Released;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = Pressed;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end
      end
      Pressed: begin
        cnt_d = '0;
        if (!s) begin
          state_d = ReleaseWait;
        end else begin
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
          if (rep_q == (rep_armed_q ? RepPeriodLast : RepDelayLast)) begin
            press_d     = 1'b1;
            rep_d       = '0;
            rep_armed_d = 1'b1;
          end else begin
            rep_d       = rep_q + 1'b1;
            rep_armed_d = rep_armed_q;
          end
`endif
        end
      end
      ReleaseWait: begin
        if (s) begin
          state_d = Pressed;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d   = Released;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end
      end
      default: begin
        state_d = Released;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/key_debounce_pulse.sv
// Push-button front end: NUM_KEYS independent synchronize/debounce/pulse channels.
// Optional auto-repeat of key_press while held: define KEY_DEBOUNCE_AUTOREPEAT_EN.
//   CLOCK_125_p : system clock
//   rst         : asynchronous active-high reset
//   key_n       : raw active-low key pins
//   key_level   : debounced key state, 1 = pressed
//   key_press   : one-cycle pulse per accepted press (and repeats when enabled)
//   key_release : one-cycle pulse per accepted release
module key_debounce_pulse
  import key_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1250000,
  parameter int unsigned REPEAT_DELAY    = 62500000,
  parameter int unsigned REPEAT_PERIOD   = 12500000
) (
  input  logic                CLOCK_125_p,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_cell (
      .clk_i    (CLOCK_125_p),
      .rst_i    (rst),
      .key_n_i  (key_n[i]),
      .level_o  (key_level[i]),
      .press_o  (key_press[i]),
      .release_o(key_release[i])
    );
  end

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Directed bench for key_debounce_pulse with DEBOUNCE_CYCLES=8: inputs change just after a
// falling edge, so the accepted pulse is seen after the 11th rising edge that follows.
module tb_key_debounce_pulse;

  localparam int unsigned NumKeys = 4;
  localparam int unsigned Db      = 8;
  localparam int unsigned RepDly  = 40;
  localparam int unsigned RepPer  = 10;
  localparam int          Lat     = 11;

  logic               clk;
  logic               rst;
  logic [NumKeys-1:0] key_n;
  logic [NumKeys-1:0] key_level;
  logic [NumKeys-1:0] key_press;
  logic [NumKeys-1:0] key_release;

  int vectors;
  int miscompares;

  key_debounce_pulse #(
    .NUM_KEYS       (NumKeys),
    .DEBOUNCE_CYCLES(Db),
    .REPEAT_DELAY   (RepDly),
    .REPEAT_PERIOD  (RepPer)
  ) dut (
    .CLOCK_125_p(clk),
    .rst        (rst),
    .key_n      (key_n),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    key_n = '1;
    tick();
    tick();
    vectors++;
    if ({key_level, key_press, key_release} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_hold got=%h want=000", {key_level, key_press, key_release});
    end
    rst = 1'b0;
    for (int n = 1; n <= 15; n++) begin
      tick();
      vectors++;
      if ({key_level, key_press, key_release} !== 12'h000) begin
        miscompares++;
        $display("FAIL reset_idle n=%0d got=%h want=000", n,
                 {key_level, key_press, key_release});
      end
    end
  endtask

  // Change key_n and check press/release/level over n cycles; pulses expected at Lat.
  task automatic run_edge(input string name, input logic [NumKeys-1:0] new_key_n,
                          input logic [NumKeys-1:0] press_mask,
                          input logic [NumKeys-1:0] rel_mask,
                          input logic [NumKeys-1:0] lvl_before,
                          input logic [NumKeys-1:0] lvl_after, input int cycles);
    logic [NumKeys-1:0] ep, er, el;
    key_n = new_key_n;
    for (int n = 1; n <= cycles; n++) begin
      tick();
      ep = (n == Lat) ? press_mask : '0;
      er = (n == Lat) ? rel_mask : '0;
      el = (n >= Lat) ? lvl_after : lvl_before;
      vectors++;
      if (key_press !== ep || key_release !== er || key_level !== el) begin
        miscompares++;
        $display("FAIL %s n=%0d press=%b rel=%b lvl=%b want press=%b rel=%b lvl=%b",
                 name, n, key_press, key_release, key_level, ep, er, el);
      end
    end
  endtask

  task automatic test_clean_press();
    run_edge("clean_press", 4'b1101, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 20);
    run_edge("clean_release", 4'b1111, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 14);
  endtask

  task automatic test_bounce();
    for (int n = 1; n <= 30; n++) begin
      key_n = (((n - 1) / 3) % 2 == 0) ? 4'b1110 : 4'b1111;
      tick();
      vectors++;
      if (key_press !== 4'b0000 || key_level !== 4'b0000 || key_release !== 4'b0000) begin
        miscompares++;
        $display("FAIL bounce n=%0d press=%b rel=%b lvl=%b want all 0", n, key_press,
                 key_release, key_level);
      end
    end
    run_edge("bounce_settle", 4'b1110, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 14);
  endtask

  task automatic test_release();
    for (int n = 1; n <= 20; n++) begin
      key_n = (n <= 5) ? 4'b1111 : 4'b1110;
      tick();
      vectors++;
      if (key_press !== 4'b0000 || key_release !== 4'b0000 || key_level !== 4'b0001) begin
        miscompares++;
        $display("FAIL glitch n=%0d press=%b rel=%b lvl=%b want 0000 0000 0001", n,
                 key_press, key_release, key_level);
      end
    end
    run_edge("release", 4'b1111, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 14);
  endtask

  task automatic test_reset_mid();
    run_edge("pre_reset_key3", 4'b0111, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 12);
    // Key 2 enters debounce at the 3rd edge, so cnt=5 after the 8th.
    key_n = 4'b0011;
    for (int n = 1; n <= 8; n++) tick();
    vectors++;
    if (key_level !== 4'b1000 || key_press !== 4'b0000) begin
      miscompares++;
      $display("FAIL pre_reset lvl=%b press=%b want lvl=1000 press=0000", key_level,
               key_press);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({key_level, key_press, key_release} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_assert got=%h want=000", {key_level, key_press, key_release});
    end
    for (int n = 1; n <= 2; n++) begin
      tick();
      vectors++;
      if ({key_level, key_press, key_release} !== 12'h000) begin
        miscompares++;
        $display("FAIL reset_mid_hold n=%0d got=%h want=000", n,
                 {key_level, key_press, key_release});
      end
    end
    rst = 1'b0;
    run_edge("post_reset_press", 4'b0011, 4'b1100, 4'b0000, 4'b0000, 4'b1100, 14);
    run_edge("post_reset_release", 4'b1111, 4'b0000, 4'b1100, 4'b1100, 4'b0000, 14);
  endtask

  task automatic test_simultaneous();
    run_edge("simul_press", 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 14);
    run_edge("simul_release", 4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 14);
  endtask

  task automatic test_repeat();
    logic [NumKeys-1:0] ep;
    key_n = 4'b1101;
    for (int n = 1; n <= Lat + 100; n++) begin
      tick();
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
      ep = (n == Lat || (n >= Lat + RepDly && (n - Lat - RepDly) % RepPer == 0)) ?
           4'b0010 : 4'b0000;
`else
      ep = (n == Lat) ? 4'b0010 : 4'b0000;
`endif
      vectors++;
      if (key_press !== ep || key_release !== 4'b0000) begin
        miscompares++;
        $display("FAIL repeat n=%0d press=%b rel=%b want press=%b rel=0000", n, key_press,
                 key_release, ep);
      end
    end
    run_edge("repeat_release", 4'b1111, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 14);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_reset_mid();
    test_simultaneous();
    test_repeat();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
